// File: rtl/multi_edge_debouncer.sv
// ============================================================================
// Module   : multi_edge_debouncer
// Purpose  : N-channel button/level event detector. Each channel has an input
//            synchronizer, a debounce counter and a stable-level FSM. A
//            per-channel edge mode selects which accepted edges produce a
//            one-cycle tick. Ticks also set sticky pending flags, and irq is
//            the OR of all pending flags.
// Ports    : clk      in   1       system clock, all logic on posedge
//            reset    in   1       synchronous, active-high reset
//            level    in   N_CH    raw asynchronous button/level inputs
//            mode     in   2*N_CH  mode[2i+1:2i]: 00 none, 01 rise, 10 fall, 11 both
//            clear    in   N_CH    per-channel pending clear
//            stable   out  N_CH    debounced level per channel
//            tick     out  N_CH    one-cycle pulse per accepted edge matching mode
//            pending  out  N_CH    sticky event flags
//            irq      out  1       OR of pending, registered with pending
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module multi_edge_debouncer #(
    parameter int N_CH        = 4,
    parameter int DB_CYCLES   = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [N_CH-1:0]   level,
    input  logic [2*N_CH-1:0] mode,
    input  logic [N_CH-1:0]   clear,
    output logic [N_CH-1:0]   stable,
    output logic [N_CH-1:0]   tick,
    output logic [N_CH-1:0]   pending,
    output logic              irq
);

    localparam int CNT_W = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
    localparam logic [CNT_W-1:0] c_CNT_MAX = CNT_W'(DB_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_LOW      = 2'd0,
        ST_LOW_CHK  = 2'd1,
        ST_HIGH     = 2'd2,
        ST_HIGH_CHK = 2'd3
    } state_t;

    logic [N_CH-1:0] w_sync_out;
    logic [N_CH-1:0] w_stable;
    logic [N_CH-1:0] w_tick_next;
    logic [N_CH-1:0] w_pending_next;
    logic [N_CH-1:0] r_tick;
    logic [N_CH-1:0] r_pending;
    logic            r_irq;

    generate
        for (genvar gi = 0; gi < N_CH; gi++) begin : g_ch

            // ---------------- input synchronizer ----------------
            if (SYNC_STAGES == 0) begin : g_nosync
                assign w_sync_out[gi] = level[gi];
            end else begin : g_sync
                // Bit 0 is the newest sample; the MSB is the synchronized output.
                logic [SYNC_STAGES-1:0] r_sync;
                always_ff @(posedge clk) begin
                    if (reset) begin
                        r_sync <= '0;
                    end else begin
                        r_sync <= (r_sync << 1) | SYNC_STAGES'(level[gi]);
                    end
                end
                assign w_sync_out[gi] = r_sync[SYNC_STAGES-1];
            end

            // ---------------- debounce FSM ----------------
            state_t           r_state;
            state_t           w_state_next;
            logic [CNT_W-1:0] r_cnt;
            logic [CNT_W-1:0] w_cnt_next;
            logic             w_s;
            logic             w_rise;
            logic             w_fall;

            assign w_s = w_sync_out[gi];

            always_ff @(posedge clk) begin
                if (reset) begin
                    r_state <= ST_LOW;
                    r_cnt   <= '0;
                end else begin
                    r_state <= w_state_next;
                    r_cnt   <= w_cnt_next;
                end
            end

            // The CHK states count agreeing samples after the first one that
            // differed from the stable level; any sample back at the old level
            // drops the candidate edge without a commit.
            always_comb begin
                w_state_next = r_state;
                w_cnt_next   = r_cnt;
                w_rise       = 1'b0;
                w_fall       = 1'b0;
                case (r_state)
                    ST_LOW: begin
                        if (w_s) begin
                            w_state_next = ST_LOW_CHK;
                            w_cnt_next   = '0;
                        end
                    end
                    ST_LOW_CHK: begin
                        if (!w_s) begin
                            w_state_next = ST_LOW;
                            w_cnt_next   = '0;
                        end else if (r_cnt == c_CNT_MAX) begin
                            w_state_next = ST_HIGH;
                            w_cnt_next   = '0;
                            w_rise       = 1'b1;
                        end else begin
                            w_cnt_next = r_cnt + CNT_W'(1);
                        end
                    end
                    ST_HIGH: begin
                        if (!w_s) begin
                            w_state_next = ST_HIGH_CHK;
                            w_cnt_next   = '0;
                        end
                    end
                    ST_HIGH_CHK: begin
                        if (w_s) begin
                            w_state_next = ST_HIGH;
                            w_cnt_next   = '0;
                        end else if (r_cnt == c_CNT_MAX) begin
                            w_state_next = ST_LOW;
                            w_cnt_next   = '0;
                            w_fall       = 1'b1;
                        end else begin
                            w_cnt_next = r_cnt + CNT_W'(1);
                        end
                    end
                    default: begin
                        w_state_next = ST_LOW;
                        w_cnt_next   = '0;
                    end
                endcase
            end

            // Stable is decoded from the registered state, so it moves on the
            // same edge as the commit that registers the tick.
            assign w_stable[gi]    = (r_state == ST_HIGH) || (r_state == ST_HIGH_CHK);
            // Mode only matters in the cycle a commit happens.
            assign w_tick_next[gi] = (w_rise & mode[2*gi]) | (w_fall & mode[2*gi+1]);
        end
    endgenerate

    // A tick arriving together with a clear wins, so the event is not lost.
    assign w_pending_next = (r_pending & ~clear) | w_tick_next;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_tick    <= '0;
            r_pending <= '0;
            r_irq     <= 1'b0;
        end else begin
            r_tick    <= w_tick_next;
            r_pending <= w_pending_next;
            r_irq     <= |w_pending_next;
        end
    end

    assign stable  = w_stable;
    assign tick    = r_tick;
    assign pending = r_pending;
    assign irq     = r_irq;

endmodule

`default_nettype wire
